// File: rtl/div_unit_pkg.sv
// Shared defines for the 32-bit iterative divider.
// State encodings, handshake constants and the 64-bit result bus type.
package div_unit_pkg;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef logic [63:0] DoubleRegBus;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step of the divider.
// Accumulator layout: {partial remainder[64:32], quotient/dividend bits[31:0]}.
module div_step (
  input  logic [64:0] i_acc,
  input  logic [31:0] i_divisor,
  output logic [64:0] o_acc
);

  logic [33:0] w_cand;
  logic [34:0] w_diff;
  logic        w_lt;
  logic [32:0] w_rem;
  logic        w_unused_top;

  // Shift the next dividend bit into the partial remainder, then trial-subtract.
  assign w_cand = {i_acc[64:32], i_acc[31]};
  assign w_diff = {1'b0, w_cand} - {3'b000, i_divisor};
  assign w_lt   = w_diff[34];
  assign w_rem  = w_lt ? w_cand[32:0] : w_diff[32:0];
  assign o_acc  = {w_rem, i_acc[30:0], ~w_lt};

  assign w_unused_top = w_cand[33] ^ w_diff[33];

endmodule

// File: rtl/div_unit.sv
// 32-bit iterative restoring divider, 64-bit {rem, quo} result.
// Signed DIV support is built only when DIV_SIGNED_EN is defined.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output DoubleRegBus result_o,
  output logic        ready_o
);

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [64:0] r_div;
  logic [31:0] r_divisor;
  logic [63:0] r_result;
  logic        r_ready;

  logic [64:0] w_next;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_accept;

  assign w_accept = (r_state == DivFree) &&
                    (start_i == DivStart) && !annul_i;

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_sgn1;
  logic w_sgn2;

  assign w_sgn1 = signed_div_i & opdata1_i[31];
  assign w_sgn2 = signed_div_i & opdata2_i[31];
  assign w_op1  = w_sgn1 ? -opdata1_i : opdata1_i;
  assign w_op2  = w_sgn2 ? -opdata2_i : opdata2_i;
  // Remainder follows the dividend's sign, quotient the XOR of signs.
  assign w_quo  = r_neg_q ? -r_div[31:0] : r_div[31:0];
  assign w_rem  = r_neg_r ? -r_div[63:32] : r_div[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_sgn1 ^ w_sgn2;
      r_neg_r <= w_sgn1;
    end
  end
`else
  logic w_unused_sign;

  assign w_unused_sign = signed_div_i;
  assign w_op1 = opdata1_i;
  assign w_op2 = opdata2_i;
  assign w_quo = r_div[31:0];
  assign w_rem = r_div[63:32];
`endif

  div_step u_step (
    .i_acc     (r_div),
    .i_divisor (r_divisor),
    .o_acc     (w_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DivFree;
      r_cnt     <= 6'd0;
      r_div     <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_ready   <= DivResultNotReady;
    end else begin
      unique case (r_state)
        DivFree: begin
          if (w_accept) begin
            r_cnt <= 6'd0;
            if (opdata2_i == 32'd0) begin
              r_state <= DivByZero;
            end else begin
              r_state   <= DivOn;
              r_div     <= {33'd0, w_op1};
              r_divisor <= w_op2;
            end
          end
        end
        DivByZero: begin
          r_state  <= DivEnd;
          r_result <= '0;
          r_ready  <= DivResultReady;
        end
        DivOn: begin
          if (annul_i) begin
            r_state  <= DivFree;
            r_cnt    <= 6'd0;
            r_result <= '0;
            r_ready  <= DivResultNotReady;
          end else if (r_cnt != 6'd32) begin
            r_div <= w_next;
            r_cnt <= r_cnt + 6'd1;
          end else begin
            r_state  <= DivEnd;
            r_cnt    <= 6'd0;
            r_result <= {w_rem, w_quo};
            r_ready  <= DivResultReady;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            r_state  <= DivFree;
            r_result <= '0;
            r_ready  <= DivResultNotReady;
          end
        end
        default: r_state <= DivFree;
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a queue scoreboard of expected results.
// Expectations adapt to whether DIV_SIGNED_EN is defined.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int nchecks = 0;
  int nerr    = 0;
  logic [63:0] exp_q[$];

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_div(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic sg,
                        input logic [63:0] exp, input int lat,
                        input int hold);
    int n;
    logic [63:0] e;
    logic [63:0] held;
    exp_q.push_back(exp);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    step();
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sg;
    n = 0;
    while (!ready_o && n < 100) begin
      chk({tag, " result0_busy"}, result_o, 64'h0);
      step();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    e = exp_q.pop_front();
    chk({tag, " result"}, result_o, e);
    held = result_o;
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, " hold_ready"}, {63'h0, ready_o}, 64'h1);
      chk({tag, " hold_result"}, result_o, held);
    end
    start_i = 1'b0;
    step();
    chk({tag, " drop_ready"}, {63'h0, ready_o}, 64'h0);
    chk({tag, " drop_result"}, result_o, 64'h0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = 32'h0;
    opdata2_i = 32'h0;
    start_i = 1'b1;
    annul_i = 1'b0;
    repeat (3) step();
    chk("reset_ready", {63'h0, ready_o}, 64'h0);
    chk("reset_result", result_o, 64'h0);
    start_i = 1'b0;
    rst = 1'b0;
    step();

    do_div("u100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 5);

`ifdef DIV_SIGNED_EN
    do_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1,
           {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0);
    do_div("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1,
           {32'h0, 32'h80000000}, 33, 0);
    do_div("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1,
           {32'd1, 32'hFFFFFFFD}, 33, 0);
`else
    do_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1,
           {32'd1, 32'h7FFFFFFC}, 33, 0);
    do_div("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1,
           {32'h80000000, 32'h0}, 33, 0);
    do_div("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1,
           {32'd7, 32'h0}, 33, 0);
`endif
    do_div("u_m2_m7", 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0,
           {32'hFFFFFFF9, 32'h0}, 33, 0);

    do_div("div0", 32'd5, 32'd0, 1'b0, 64'h0, 1, 2);
    do_div("u_big", 32'hFFFFFFFF, 32'h80000001, 1'b0,
           {32'h7FFFFFFE, 32'h1}, 33, 1);

    // Annul part-way through an iteration.
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    step();
    repeat (10) step();
    annul_i = 1'b1;
    start_i = 1'b0;
    step();
    annul_i = 1'b0;
    chk("annul_ready", {63'h0, ready_o}, 64'h0);
    chk("annul_result", result_o, 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ready_o) seen = 1'b1;
    end
    chk("annul_never_ready", {63'h0, seen}, 64'h0);
    do_div("after_annul", 32'd12, 32'd4, 1'b0, {32'd0, 32'd3}, 33, 0);

    // Reset part-way through an iteration.
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    step();
    repeat (20) step();
    rst = 1'b1;
    start_i = 1'b0;
    step();
    chk("midrst_ready", {63'h0, ready_o}, 64'h0);
    chk("midrst_result", result_o, 64'h0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ready_o) seen = 1'b1;
    end
    chk("midrst_never_ready", {63'h0, seen}, 64'h0);
    do_div("after_rst", 32'hFFFFFFFF, 32'h10, 1'b0,
           {32'hF, 32'h0FFFFFFF}, 33, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 32-bit operands and a 64-bit result.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled only on start acceptance.
REQ-005 opdata1_i  input  32  dividend; sampled on start acceptance.
REQ-006 opdata2_i  input  32  divisor; sampled on start acceptance.
REQ-007 start_i  input  1  request from the EX stage; held high until ready_o is seen.
REQ-008 annul_i  input  1  abort request (flush or exception).
REQ-009 result_o  output  64  {remainder[63:32], quotient[31:0]}, written to {HI,LO} by EX.
REQ-010 ready_o  output  1  result valid.

Function
REQ-011 SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-012 FREE: on start_i=1 and annul_i=0, SHALL go to BYZERO if opdata2_i==0, else to ON and load the operands; otherwise SHALL stay in FREE.
REQ-013 BYZERO: SHALL go to END the next edge with result 64'h0.
REQ-014 ON: SHALL perform one restoring shift-subtract step per cycle, using a 6-bit counter from 0 to 31.
REQ-015 ON: after the 32nd step, SHALL go to END the next edge, registering the final result and setting ready_o=1.
REQ-016 Latency SHALL be as follows, where E0 is the acceptance edge: for a nonzero divisor, ready_o goes high after edge E33; for a zero divisor, after edge E1.
REQ-017 ON with annul_i=1: SHALL go to FREE the next edge, with ready_o=0, result_o=0, and the counter cleared.
REQ-018 END: while start_i=1, SHALL hold ready_o=1 and result_o stable.
REQ-019 END with start_i=0: SHALL go to FREE the next edge, with ready_o=0 and result_o=0.
REQ-020 result_o SHALL be 0 whenever ready_o=0.
REQ-021 annul_i in FREE or END SHALL have no effect beyond REQ-012 (an annulled start is not accepted).
REQ-022 Signed mode, operands: any negative operand SHALL be two's-complement negated before iteration.
REQ-023 Signed mode, quotient: SHALL be negated when the operand signs differ.
REQ-024 Signed mode, remainder: SHALL be negated when the dividend is negative, so the remainder takes the dividend's sign.
REQ-025 0x80000000 / 0xFFFFFFFF (signed) SHALL wrap modulo 2^32: quotient 0x80000000, remainder 0.
REQ-026 Operand changes after acceptance SHALL NOT affect the result in progress.

Reset
REQ-027 rst=1 SHALL force the following at the next edge, overriding all other inputs, including mid-division: state FREE, ready_o=0, result_o=64'h0, counter=0, internal dividend/divisor registers=0.

Configuration
REQ-028 Macro DIV_SIGNED_EN defined: signed_div_i SHALL behave per REQ-022 to REQ-025.
REQ-029 DIV_SIGNED_EN undefined: signed_div_i SHALL be ignored, all divisions SHALL be unsigned, and the negation logic SHALL be absent.

Structure
REQ-030 The shared package (defines) SHALL hold:
  - FSM state encodings (DivFree, DivByZero, DivOn, DivEnd);
  - DivResultReady/NotReady and DivStart/DivStop constants;
  - DoubleRegBus.
REQ-031 SHALL contain one sub-module, div_step: purely combinational; input is a 65-bit partial remainder/quotient and a 32-bit divisor; output is the next 65-bit value.
REQ-032 All state SHALL be held in div_unit; div_step SHALL hold no registers.

Verification
REQ-033 Unsigned 100 / 7, start held -> ready_o high after E33; result_o={32'd2, 32'd14}.
REQ-034 Signed 0xFFFFFFF9 / 2 (-7/2) -> result_o={32'hFFFFFFFF, 32'hFFFFFFFD}; with DIV_SIGNED_EN undefined -> {32'd1, 32'h7FFFFFFC}.
REQ-035 5 / 0 -> ready_o high after E1; result_o=0.
REQ-036 annul_i pulsed at step 10 -> FREE next edge, ready_o never rises; a new start 12 / 4 then returns {0, 3} after E33.
REQ-037 Signed 0x80000000 / 0xFFFFFFFF -> result_o={32'h0, 32'h80000000}.
REQ-038 start_i held 5 cycles in END -> ready_o/result_o stable; start_i dropped -> both 0 the next edge. rst asserted at step 20 -> FREE, outputs 0 the next edge.
